pid_rx_tracker: RTL and testbench
=================================

Name: pid_rx_tracker

Overview:
- Parametrised USB PID receive stage. Captures the PID byte from the receive shifter and runs a full 8-bit check: check nibble must be the complement of the PID, and the PID must be in a configurable accepted set.
- Classifies the PID (token / data / handshake) and tracks the DATA0/DATA1 toggle per endpoint, flagging sequence mismatches.
- Sits between the receive byte decoder and the RX control FSM.

Parameters:
- NUM_EP, 4, number of endpoints with tracked data toggle (1..16).
- EP_W, 2, width of ep_sel. Must satisfy 2^EP_W >= NUM_EP.
- ACCEPT_MASK, 16'h6E0E, bit n set means PID nibble n is accepted. Default accepts OUT=1, ACK=2, DATA0=3, IN=9, NAK=A, DATA1=B, SETUP=D, STALL=E.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- rcv_data  in  8  received PID byte; [3:0]=PID, [7:4]=check nibble (must be ~[3:0])
- pid_load  in  1  strobe: capture rcv_data this cycle
- pid_clear  in  1  strobe: discard held PID
- ep_sel  in  EP_W  endpoint addressed by the current transaction
- toggle_update  in  1  strobe: flip expected toggle of ep_sel (successful data handshake)
- toggle_reset  in  1  strobe: force expected toggle of ep_sel to DATA0
- pid  out  4  held PID nibble
- pid_valid  out  1  one-cycle pulse: a load passed all checks
- pid_err  out  1  level: held PID failed check/accept; held until clear or next load
- toggle_err  out  1  one-cycle pulse: data PID toggle mismatch
- overrun  out  1  sticky: load arrived while state HELD; cleared only by pid_clear
- is_token  out  1  pid in {OUT, IN, SETUP}, state HELD only
- is_data  out  1  pid in {DATA0, DATA1}, state HELD only
- is_handshake  out  1  pid in {ACK, NAK, STALL}, state HELD only
- exp_toggle  out  NUM_EP  expected toggle per endpoint (0=DATA0, 1=DATA1)

Behaviour:
- Reset: state EMPTY; pid=4'h0; pid_valid, pid_err, toggle_err, overrun all 0; exp_toggle all 0; is_* 0.
- All outputs are registered. Results of a load appear the cycle after pid_load is high (latency 1).
- States:
  - EMPTY: no PID held.
  - HELD: valid PID held.
  - ERR: invalid PID held.
- Load evaluation: chk_ok = (rcv_data[7:4] == ~rcv_data[3:0]); acc_ok = ACCEPT_MASK[rcv_data[3:0]].
  - pid <= rcv_data[3:0] regardless of outcome.
  - chk_ok && acc_ok: go to HELD, pulse pid_valid, pid_err=0.
  - Otherwise: go to ERR, pid_err=1, no pid_valid.
- Transitions:
  - EMPTY/ERR, pid_load: evaluate as above.
  - HELD, pid_load: re-evaluate as above and also set overrun.
  - Any state, pid_clear and no pid_load: go to EMPTY, pid_err=0, overrun=0; pid keeps its value.
  - pid_load and pid_clear together: load wins; overrun is not cleared.
- Toggle check runs only when the load passes and the PID is DATA0 (3) or DATA1 (B):
  - Compare pid[3] with exp_toggle[ep_sel]. On mismatch, pulse toggle_err alongside pid_valid.
  - pid_valid still pulses on mismatch; the RX FSM decides whether to discard the packet.
  - exp_toggle is not changed by loads.
- toggle_update: exp_toggle[ep_sel] flips the next cycle.
- toggle_reset: exp_toggle[ep_sel] <= 0. If toggle_update and toggle_reset are both high, reset wins.
- Toggle ops and a data load in the same cycle: the check uses the pre-update exp_toggle.
- ep_sel >= NUM_EP: toggle_update and toggle_reset are ignored, toggle_err is never raised, pid_valid is unaffected.
- Reset asserted mid-operation: everything returns to reset values immediately; pending pulses are lost.

Test Plan:
- Reset, then idle 5 cycles -> pid=0, all flags 0, exp_toggle=4'b0000.
- Load 8'hB4 (SETUP D? no: PID=4, check=B, not accepted) -> next cycle pid=4, pid_err=1, pid_valid=0. Then pid_clear -> pid_err=0, state EMPTY.
- Load 8'h87 (PID=7, check=8, complement ok; 7 not in ACCEPT_MASK) -> pid_err=1. Load 8'h97 (bad complement) -> pid_err=1.
- Load 8'hE1 (OUT) -> pid_valid pulse, is_token=1. Load 8'hD2 (ACK) without clear -> pid_valid, is_handshake=1, overrun=1. pid_clear -> overrun=0.
- ep_sel=2: load 8'hC3 (DATA0) -> pid_valid, no toggle_err. toggle_update -> exp_toggle[2]=1. Load 8'hC3 again -> toggle_err pulse. Load 8'h4B (DATA1) -> no toggle_err.
- ep_sel=1: toggle_update and toggle_reset in the same cycle -> exp_toggle[1]=0. ep_sel=3 with NUM_EP=3 and toggle_update -> exp_toggle unchanged. pid_load and pid_clear together with 8'h69 (IN) -> pid_valid, state HELD.

Source files
------------

// File: rtl/pid_rx_tracker.sv
// USB PID receive stage: captures and validates the PID byte, classifies it,
// and tracks the expected DATA0/DATA1 toggle per endpoint.
module pid_rx_tracker #(
    parameter int          NUM_EP      = 4,
    parameter int          EP_W        = 2,
    parameter logic [15:0] ACCEPT_MASK = 16'h6E0E
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [7:0]        rcv_data,
    input  logic              pid_load,
    input  logic              pid_clear,
    input  logic [EP_W-1:0]   ep_sel,
    input  logic              toggle_update,
    input  logic              toggle_reset,
    output logic [3:0]        pid,
    output logic              pid_valid,
    output logic              pid_err,
    output logic              toggle_err,
    output logic              overrun,
    output logic              is_token,
    output logic              is_data,
    output logic              is_handshake,
    output logic [NUM_EP-1:0] exp_toggle
);

    typedef enum logic [1:0] {ST_EMPTY, ST_HELD, ST_ERR} state_t;

    state_t             state, state_n;
    logic [3:0]         pid_n;
    logic               valid_n, err_n, terr_n, ovr_n;
    logic               tok_n, data_n, hs_n;
    logic [NUM_EP-1:0]  exp_n;
    logic               chk_ok, acc_ok, is_data_pid;
    logic               ep_hit, exp_cur;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= ST_EMPTY;
            pid          <= 4'h0;
            pid_valid    <= 1'b0;
            pid_err      <= 1'b0;
            toggle_err   <= 1'b0;
            overrun      <= 1'b0;
            is_token     <= 1'b0;
            is_data      <= 1'b0;
            is_handshake <= 1'b0;
            exp_toggle   <= '0;
        end else begin
            state        <= state_n;
            pid          <= pid_n;
            pid_valid    <= valid_n;
            pid_err      <= err_n;
            toggle_err   <= terr_n;
            overrun      <= ovr_n;
            is_token     <= tok_n;
            is_data      <= data_n;
            is_handshake <= hs_n;
            exp_toggle   <= exp_n;
        end
    end

    always_comb begin
        chk_ok      = (rcv_data[7:4] == ~rcv_data[3:0]);
        acc_ok      = ACCEPT_MASK[rcv_data[3:0]];
        is_data_pid = (rcv_data[2:0] == 3'b011);

        // Out-of-range endpoints never match, so they neither toggle nor flag.
        ep_hit  = 1'b0;
        exp_cur = 1'b0;
        exp_n   = exp_toggle;
        for (int i = 0; i < NUM_EP; i++) begin
            if (int'(ep_sel) == i) begin
                ep_hit  = 1'b1;
                exp_cur = exp_toggle[i];
                if (toggle_reset)
                    exp_n[i] = 1'b0;
                else if (toggle_update)
                    exp_n[i] = ~exp_toggle[i];
            end
        end

        state_n = state;
        pid_n   = pid;
        valid_n = 1'b0;
        err_n   = pid_err;
        terr_n  = 1'b0;
        ovr_n   = overrun;

        if (pid_load) begin
            pid_n = rcv_data[3:0];
            if (state == ST_HELD)
                ovr_n = 1'b1;
            if (chk_ok && acc_ok) begin
                state_n = ST_HELD;
                valid_n = 1'b1;
                err_n   = 1'b0;
                terr_n  = is_data_pid && ep_hit && (rcv_data[3] != exp_cur);
            end else begin
                state_n = ST_ERR;
                err_n   = 1'b1;
            end
        end else if (pid_clear) begin
            state_n = ST_EMPTY;
            err_n   = 1'b0;
            ovr_n   = 1'b0;
        end

        tok_n  = (state_n == ST_HELD) && (pid_n == 4'h1 || pid_n == 4'h9 || pid_n == 4'hD);
        data_n = (state_n == ST_HELD) && (pid_n == 4'h3 || pid_n == 4'hB);
        hs_n   = (state_n == ST_HELD) && (pid_n == 4'h2 || pid_n == 4'hA || pid_n == 4'hE);
    end

endmodule

// File: tb/tb_pid_rx_tracker.sv
// Directed bench for pid_rx_tracker; a second NUM_EP=3 instance covers out-of-range endpoints.
module tb_pid_rx_tracker;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic       pid_load = 1'b0, pid_clear = 1'b0;
    logic [1:0] ep_sel = 2'd0;
    logic       toggle_update = 1'b0, toggle_reset = 1'b0;

    logic [3:0] pid, pid3;
    logic       pid_valid, pid_err, toggle_err, overrun;
    logic       is_token, is_data, is_handshake;
    logic       pid_valid3, pid_err3, toggle_err3, overrun3;
    logic       is_token3, is_data3, is_handshake3;
    logic [3:0] exp_toggle;
    logic [2:0] exp_toggle3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pid_rx_tracker dut (
        .clk(clk), .n_rst(n_rst), .rcv_data(rcv_data), .pid_load(pid_load),
        .pid_clear(pid_clear), .ep_sel(ep_sel), .toggle_update(toggle_update),
        .toggle_reset(toggle_reset), .pid(pid), .pid_valid(pid_valid),
        .pid_err(pid_err), .toggle_err(toggle_err), .overrun(overrun),
        .is_token(is_token), .is_data(is_data), .is_handshake(is_handshake),
        .exp_toggle(exp_toggle)
    );

    pid_rx_tracker #(.NUM_EP(3), .EP_W(2)) dut3 (
        .clk(clk), .n_rst(n_rst), .rcv_data(rcv_data), .pid_load(pid_load),
        .pid_clear(pid_clear), .ep_sel(ep_sel), .toggle_update(toggle_update),
        .toggle_reset(toggle_reset), .pid(pid3), .pid_valid(pid_valid3),
        .pid_err(pid_err3), .toggle_err(toggle_err3), .overrun(overrun3),
        .is_token(is_token3), .is_data(is_data3), .is_handshake(is_handshake3),
        .exp_toggle(exp_toggle3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        pid_load      = 1'b0;
        pid_clear     = 1'b0;
        toggle_update = 1'b0;
        toggle_reset  = 1'b0;
    endtask

    task automatic load(input logic [7:0] d, input logic clr);
        rcv_data  = d;
        pid_load  = 1'b1;
        pid_clear = clr;
        tick();
    endtask

    task automatic clear();
        pid_clear = 1'b1;
        tick();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (5) tick();
        chk("rst_pid", pid, 4'h0);
        chk("rst_flags", {pid_valid, pid_err, toggle_err, overrun}, 4'b0000);
        chk("rst_class", {is_token, is_data, is_handshake}, 3'b000);
        chk("rst_exp", exp_toggle, 4'b0000);

        // Bad check nibble / not accepted
        load(8'hB4, 1'b0);
        chk("b4_pid", pid, 4'h4);
        chk("b4_err", pid_err, 1'b1);
        chk("b4_valid", pid_valid, 1'b0);
        clear();
        chk("b4_clr_err", pid_err, 1'b0);
        chk("b4_clr_pid", pid, 4'h4);
        load(8'h87, 1'b0);
        chk("87_err", {pid_err, pid_valid, pid}, {1'b1, 1'b0, 4'h7});
        load(8'h97, 1'b0);
        chk("97_err", {pid_err, pid_valid, overrun}, 3'b100);

        // Token then handshake without clear
        load(8'hE1, 1'b0);
        chk("e1_valid", {pid_valid, pid_err, is_token, overrun}, 4'b1010);
        tick();
        chk("e1_pulse", {pid_valid, is_token}, 2'b01);
        load(8'hD2, 1'b0);
        chk("d2_hs", {pid_valid, is_handshake, is_token, overrun}, 4'b1101);
        clear();
        chk("d2_clr", {overrun, is_handshake, pid_err}, 3'b000);

        // Data toggle tracking on endpoint 2
        ep_sel = 2'd2;
        load(8'hC3, 1'b0);
        chk("c3_first", {pid_valid, toggle_err, is_data}, 3'b101);
        toggle_update = 1'b1;
        tick();
        chk("upd_ep2", exp_toggle, 4'b0100);
        load(8'hC3, 1'b0);
        chk("c3_mismatch", {pid_valid, toggle_err}, 2'b11);
        tick();
        chk("terr_pulse", toggle_err, 1'b0);
        load(8'h4B, 1'b0);
        chk("4b_match", {pid_valid, toggle_err, pid}, {1'b1, 1'b0, 4'hB});
        toggle_update = 1'b1;
        load(8'h4B, 1'b0);
        chk("preupd_check", toggle_err, 1'b0);
        chk("preupd_exp", exp_toggle, 4'b0000);

        // Endpoint 1: reset beats update
        ep_sel = 2'd1;
        toggle_update = 1'b1;
        tick();
        chk("upd_ep1", exp_toggle, 4'b0010);
        toggle_update = 1'b1;
        toggle_reset  = 1'b1;
        tick();
        chk("rst_wins", exp_toggle, 4'b0000);

        // Endpoint 3 is out of range for the NUM_EP=3 instance
        ep_sel = 2'd3;
        toggle_update = 1'b1;
        tick();
        chk("ep3_in_range", exp_toggle, 4'b1000);
        chk("ep3_ignored", exp_toggle3, 3'b000);
        load(8'hC3, 1'b0);
        chk("ep3_terr", toggle_err, 1'b1);
        chk("ep3_terr_oor", {pid_valid3, toggle_err3}, 2'b10);

        // Load and clear together: load wins
        clear();
        load(8'h69, 1'b1);
        chk("69_lc", {pid_valid, is_token, pid_err, overrun, pid}, {4'b1100, 4'h9});
        load(8'h69, 1'b1);
        chk("69_lc_ovr", {pid_valid, overrun}, 2'b11);

        // Asynchronous reset mid-operation
        rcv_data = 8'h2D;
        pid_load = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        chk("async_rst", {pid, pid_valid, pid_err, toggle_err, overrun, is_token, is_data, is_handshake},
            {4'h0, 7'b0});
        chk("async_rst_exp", exp_toggle, 4'b0000);
        pid_load = 1'b0;
        @(posedge clk);
        #1 n_rst = 1'b1;
        tick();
        chk("post_rst", {pid_valid, pid_err}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
